// File: rtl/sub_bytes_serial_if.sv
// Handshake bundle for the serial SubBytes stage:
// an upstream block port and a downstream result port.
interface sub_bytes_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_side;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_side, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_side, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/sub_bytes_serial.sv
// AES SubBytes over a 128-bit state, LANES bytes per cycle,
// with forward/inverse selection latched per block.
module sbox_implementation (
    input  logic       i_side,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 in GF(2^8) is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(
        input logic [7:0] b,
        input int         n
    );
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv;
    logic [7:0] w_fwd;

    always_comb begin
        w_pre = i_data;
        if (i_side)
            w_pre = rotl(i_data, 1) ^ rotl(i_data, 3)
                  ^ rotl(i_data, 6) ^ 8'h05;
        w_inv = ginv(w_pre);
        w_fwd = w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2)
              ^ rotl(w_inv, 3) ^ rotl(w_inv, 4) ^ 8'h63;
        o_data = i_side ? w_inv : w_fwd;
    end
endmodule

module sub_bytes_serial #(
    parameter int LANES = 1
) (
    input logic              clk,
    input logic              rst_n,
    sub_bytes_serial_if.slave bus
);
    localparam int         GROUPS = 16 / LANES;
    localparam logic [3:0] LAST   = 4'(GROUPS - 1);

    if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
        $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       r_state;
    state_t       w_state_nx;
    logic [127:0] r_work;
    logic         r_side;
    logic [3:0]   r_cnt;

    logic [7:0]   w_bytes    [16];
    logic [7:0]   w_upd      [16];
    logic [127:0] w_next;
    logic [7:0]   w_sb_in    [LANES];
    logic [7:0]   w_sb_out   [LANES];
    logic [3:0]   w_lane_idx [LANES];
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign w_bytes[i]             = r_work[127-8*i -: 8];
        assign w_next[127-8*i -: 8]   = w_upd[i];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_idx[k] = 4'(int'(r_cnt) * LANES + k);
        assign w_sb_in[k]    = w_bytes[w_lane_idx[k]];
        sbox_implementation u_sbox (
            .i_side (r_side),
            .i_data (w_sb_in[k]),
            .o_data (w_sb_out[k])
        );
    end

    always_comb begin
        w_upd = w_bytes;
        for (int k = 0; k < LANES; k++)
            w_upd[w_lane_idx[k]] = w_sb_out[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nx = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) w_state_nx = DONE;
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work <= '0;
            r_side <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_work <= bus.in_state;
            r_side <= bus.in_side;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_work <= w_next;
            r_cnt  <= (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_state = r_work;
    assign bus.busy      = w_busy;
endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Sequential AES SubBytes stage. It accepts a 128-bit AES state over a valid/ready handshake and substitutes all 16 bytes, LANES bytes per cycle, through LANES shared instances of `sbox_implementation`. Forward or inverse substitution is selected per block. The result goes downstream to ShiftRows (forward) or AddRoundKey (inverse) over a second valid/ready handshake. The block trades area for latency: LANES=1 uses a single S-box.

## Interface

- LANES, default 1: number of `sbox_implementation` instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream offers a block.
- in_ready  output  1  block can accept a block.
- in_state  input  128  AES state, byte i = bits [127-8i -: 8], FIPS-197 column-major byte order.
- in_side  input  1  0 = forward S-box, 1 = inverse S-box; same meaning as the `sbox_implementation` side input.
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream accepts the block.
- out_state  output  128  substituted state, same byte order as in_state.
- busy  output  1  high in RUN or DONE.

## Operation

- Registers:
  - work[127:0]: working state; out_state is driven directly from it.
  - side_q: latched in_side.
  - cnt: group index, 4 bits.
  - state: FSM ∈ {IDLE, RUN, DONE}.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, at the edge: work←in_state, side_q←in_side, cnt←0, state→RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, S-box lane k maps byte (cnt·LANES+k) of work using side_q. The results are written back into the same byte positions at the edge; all other bytes are unchanged.
  - cnt←cnt+1.
  - When cnt = 16/LANES−1, the edge writes the last group, cnt←0, and state→DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - work is held stable until out_valid && out_ready. At that edge state→IDLE; work is retained (not cleared).
- The S-box path is purely combinational within RUN. The stage adds no extra pipeline registers beyond work.
- side_q governs the whole block. Changes on in_side or in_state after acceptance are ignored.
- No overlap: a new block is accepted only in IDLE, so in_ready = (state==IDLE).
- Reset (rst_n=0 at an edge):
  - state→IDLE, work←0, side_q←0, cnt←0.
  - Resulting outputs: in_ready=1, out_valid=0, out_state=0, busy=0.
  - Reset mid-RUN or mid-DONE aborts the block; no out_valid is produced for it.
  - While rst_n=0, in_valid is ignored.

## Timing

- Acceptance edge E0 (IDLE, in_valid=1).
- RUN occupies edges E1..E(16/LANES); out_valid rises after edge E(16/LANES).
  - LANES=1: 16 cycles.
  - LANES=16: 1 cycle.
- The handshake-out edge returns to IDLE; the earliest next acceptance is the following edge.
- Minimum block period: 16/LANES + 2 cycles.
- Backpressure: out_ready=0 holds DONE indefinitely, with out_state and out_valid stable.
- in_valid held high with out_ready tied high gives back-to-back blocks at the minimum period.
- out_valid is a registered-state decode (state==DONE); it has no combinational path from in_valid.
- in_ready has no combinational path from out_ready.

## Test plan

- Forward FIPS-197 vector, LANES=1:
  - Stimulus: in_state=193de3bea0f4e22b9ac68d2ae9f84808, side 0, out_ready=1.
  - Response: out_state=d42711aee0bf98f1b8b45de51e415230, with out_valid exactly 16 cycles after acceptance.
- Inverse round-trip, LANES=4:
  - Stimulus: feed d42711aee0bf98f1b8b45de51e415230 with side 1.
  - Response: 193de3bea0f4e22b9ac68d2ae9f84808 after 4 cycles.
- Corner bytes:
  - Stimulus: in_state=00000000000000000000000000000000, side 0.
  - Response: 6363…63 (all 16 bytes 63).
  - Stimulus: 000153ff repeated 4 times, side 0.
  - Response: 637ced16 repeated 4 times.
- Backpressure and input isolation:
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises. Toggle in_valid, in_state and in_side throughout.
  - Response: in_ready=0, out_state unchanged, no second acceptance; block completes when out_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at RUN cycle 7 (LANES=1).
  - Response: next cycle in_ready=1, out_valid=0, out_state=0; a following block produces correct output.
- Back-to-back throughput:
  - Stimulus: 3 blocks with in_valid and out_ready held high, LANES=16.
  - Response: out_valid pulses spaced 3 cycles apart, each with the correct S-box result.
